// File: rtl/edge_detect_pkg.sv
// ---------------------------------------------------------------------------
// edge_detect_pkg
//   Shared definitions for the multi-channel edge detector.
//   - edge_mode_e : per-channel edge selection (off / rising / falling / both)
//   - MODE_W      : width of one channel's mode field in the packed mode bus
//   - mode_accepts: decides whether a level change counts as an event for a
//                   given mode
// ---------------------------------------------------------------------------
package edge_detect_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  // rise/fall are mutually exclusive single-cycle indications that the
  // filtered level changed in that direction.
  function automatic logic mode_accepts(input edge_mode_e mode,
                                        input logic       rise,
                                        input logic       fall);
    logic acc;
    acc = 1'b0;
    case (mode)
      MODE_OFF:  acc = 1'b0;
      MODE_RISE: acc = rise;
      MODE_FALL: acc = fall;
      MODE_BOTH: acc = rise | fall;
      default:   acc = 1'b0;
    endcase
    return acc;
  endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// ---------------------------------------------------------------------------
// edge_detect_chan
//   One trigger channel: synchroniser -> glitch filter -> edge qualification
//   -> pulse stretcher -> sticky flag.
//
// Ports
//   clk, rst_n          : system clock, synchronous active-low reset
//   trigger_i           : raw asynchronous input
//   mode_i              : edge selection (see edge_mode_e)
//   out_active_high_i   : 1 = pulse_o active high, 0 = active low
//   sticky_clr_i        : level-sensitive clear of sticky_o
//   pulse_o             : stretched pulse in the selected polarity
//   p_int_o             : stretched pulse, always active high
//   level_o             : filtered, synchronised trigger level
//   sticky_o            : latched "event seen" flag
// ---------------------------------------------------------------------------
module edge_detect_chan
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int PULSE_LEN     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              out_active_high_i,
  input  logic              sticky_clr_i,
  output logic              pulse_o,
  output logic              p_int_o,
  output logic              level_o,
  output logic              sticky_o
);

  localparam int CNT_W = $clog2(FILTER_CYCLES) + 1;
  localparam int STR_W = $clog2(PULSE_LEN + 1);

  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [STR_W-1:0] STR_LOAD  = STR_W'(PULSE_LEN);

  // State
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic                   level_prev_q, level_prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STR_W-1:0]       str_q, str_d;
  logic                   sticky_q, sticky_d;

  // Combinational helpers
  logic sync_out;
  logic level_rise;
  logic level_fall;
  logic event_hit;

  always_comb begin
    // Synchroniser: bit 0 takes the raw input, the MSB is the settled value.
    sync_d   = {sync_q[SYNC_STAGES-2:0], trigger_i};
    sync_out = sync_q[SYNC_STAGES-1];

    // Glitch filter: a differing level must be seen for FILTER_CYCLES
    // consecutive edges before it is accepted. Any return to the current
    // level restarts the count.
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_out == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == FILT_LAST) begin
      level_d = sync_out;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Edge detection compares the filtered level with its one-cycle-old copy,
    // so an event is seen the cycle after the level flips. The filter runs
    // independently of mode, so changing mode never manufactures an edge.
    level_prev_d = level_q;
    level_rise   = level_q & ~level_prev_q;
    level_fall   = ~level_q & level_prev_q;
    event_hit    = mode_accepts(edge_mode_e'(mode_i), level_rise, level_fall);

    // Stretcher: an event (re)loads the full length, so back-to-back events
    // extend the pulse rather than producing separate pulses. The reload has
    // priority over the decrement, so expiry and a new event on the same edge
    // keep the pulse high.
    str_d = str_q;
    if (event_hit) begin
      str_d = STR_LOAD;
    end else if (str_q != '0) begin
      str_d = str_q - 1'b1;
    end

    // Sticky: set has priority over clear.
    sticky_d = event_hit | (sticky_q & ~sticky_clr_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q       <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
      str_q        <= '0;
      sticky_q     <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      cnt_q        <= cnt_d;
      str_q        <= str_d;
      sticky_q     <= sticky_d;
    end
  end

  assign p_int_o  = (str_q != '0);
  // Polarity is applied combinationally so a polarity change is immediate.
  assign pulse_o  = out_active_high_i ? p_int_o : ~p_int_o;
  assign level_o  = level_q;
  assign sticky_o = sticky_q;

endmodule

// File: rtl/edge_detect_multi.sv
// ---------------------------------------------------------------------------
// edge_detect_multi
//   CHANNELS independent edge detectors for asynchronous trigger inputs.
//
// Ports
//   clk, rst_n        : system clock, synchronous active-low reset
//   trigger           : raw asynchronous inputs, one per channel
//   mode              : per channel bits [2i+1:2i], 00 off / 01 rise /
//                       10 fall / 11 both
//   out_active_high   : per-channel pulse polarity (1 = active high)
//   sticky_clr        : per-channel level-sensitive sticky clear
//   pulse             : stretched event pulses, per-channel polarity
//   level             : filtered, synchronised trigger levels
//   sticky            : latched event flags
//   any_pulse         : OR of all active-high internal pulses
// ---------------------------------------------------------------------------
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int CHANNELS      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int PULSE_LEN     = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS-1:0]        trigger,
  input  logic [MODE_W*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]        out_active_high,
  input  logic [CHANNELS-1:0]        sticky_clr,
  output logic [CHANNELS-1:0]        pulse,
  output logic [CHANNELS-1:0]        level,
  output logic [CHANNELS-1:0]        sticky,
  output logic                       any_pulse
);

  // Active-high pulses, independent of each channel's output polarity.
  logic [CHANNELS-1:0] p_int;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    edge_detect_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .PULSE_LEN    (PULSE_LEN)
    ) u_chan (
      .clk              (clk),
      .rst_n            (rst_n),
      .trigger_i        (trigger[gi]),
      .mode_i           (mode[gi*MODE_W +: MODE_W]),
      .out_active_high_i(out_active_high[gi]),
      .sticky_clr_i     (sticky_clr[gi]),
      .pulse_o          (pulse[gi]),
      .p_int_o          (p_int[gi]),
      .level_o          (level[gi]),
      .sticky_o         (sticky[gi])
    );
  end

  assign any_pulse = |p_int;

endmodule
